// File: rtl/convertidor_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// (double dabble). Optional zero-blanking output is enabled by BCD_APAGAR_CEROS_EN.
package convertidor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DESPLAZA,
        FIN
    } estado_t;

    localparam int unsigned ANCHO_DIGITO = 4;
    localparam logic [ANCHO_DIGITO-1:0] UMBRAL_AJUSTE = 4'd5;
    localparam logic [ANCHO_DIGITO-1:0] AJUSTE = 4'd3;

    // Counter must hold the value N_BITS itself, hence clog2(N_BITS+1).
    function automatic int unsigned ancho_contador(input int unsigned n_bits);
        int unsigned ancho;
        ancho = $clog2(n_bits + 1);
        return (ancho < 1) ? 1 : ancho;
    endfunction

endpackage

// File: rtl/convertidor_bin_bcd_seq_ajuste_digito.sv
// Combinational add-3 cell: a BCD digit of 5 or more gets +3 before the next shift.
module ajuste_digito
    import convertidor_pkg::*;
(
    input  logic [ANCHO_DIGITO-1:0] digito,
    output logic [ANCHO_DIGITO-1:0] ajustado
);

    always_comb begin
        ajustado = digito;
        if (digito >= UMBRAL_AJUSTE) begin
            ajustado = digito + AJUSTE;
        end
    end

endmodule

// File: rtl/convertidor_bin_bcd_seq.sv
// Sequential N_BITS-to-BCD converter with start/done handshake and overflow flag.
// Define BCD_APAGAR_CEROS_EN to add the leading-zero blanking output 'apagar'.
module convertidor_bin_bcd_seq
    import convertidor_pkg::*;
#(
    parameter int unsigned N_BITS    = 10,
    parameter int unsigned N_DIGITOS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inicio,
    input  logic [N_BITS-1:0]               N_Binario,
    output logic                            ocupado,
    output logic                            listo,
    output logic [ANCHO_DIGITO*N_DIGITOS-1:0] BCD,
    output logic                            desborde
`ifdef BCD_APAGAR_CEROS_EN
    ,
    output logic [N_DIGITOS-1:0]            apagar
`endif
);

    localparam int unsigned ANCHO_BCD = ANCHO_DIGITO * N_DIGITOS;
    localparam int unsigned ANCHO_CNT = ancho_contador(N_BITS);
    localparam logic [ANCHO_CNT-1:0] CNT_CARGA = ANCHO_CNT'(N_BITS);
    localparam logic [ANCHO_CNT-1:0] CNT_UNO   = ANCHO_CNT'(1);

    estado_t                 estado;
    logic [ANCHO_CNT-1:0]    cnt;
    logic [N_BITS-1:0]       desp;
    logic [ANCHO_BCD-1:0]    acum;
    logic [ANCHO_BCD-1:0]    acum_aj;
    logic                    sticky;
    logic [ANCHO_BCD+N_BITS-1:0] desplazado;

    for (genvar i = 0; i < N_DIGITOS; i++) begin : g_ajuste
        ajuste_digito u_ajuste (
            .digito   (acum[i*ANCHO_DIGITO +: ANCHO_DIGITO]),
            .ajustado (acum_aj[i*ANCHO_DIGITO +: ANCHO_DIGITO])
        );
    end

    assign desplazado = {acum_aj, desp} << 1;

`ifdef BCD_APAGAR_CEROS_EN
    logic [N_DIGITOS-1:0] apagar_d;
    logic                 ceros_arriba;

    // Digit 0 is never blanked so a zero result still shows one "0".
    always_comb begin
        apagar_d     = '0;
        ceros_arriba = 1'b1;
        for (int i = int'(N_DIGITOS) - 1; i >= 1; i--) begin
            ceros_arriba = ceros_arriba & (acum[i*ANCHO_DIGITO +: ANCHO_DIGITO] == '0);
            apagar_d[i]  = ceros_arriba;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= IDLE;
            cnt      <= '0;
            desp     <= '0;
            acum     <= '0;
            sticky   <= 1'b0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
            BCD      <= '0;
            desborde <= 1'b0;
`ifdef BCD_APAGAR_CEROS_EN
            apagar   <= '0;
`endif
        end else begin
            listo <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (inicio) begin
                        desp    <= N_Binario;
                        acum    <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_CARGA;
                        ocupado <= 1'b1;
                        estado  <= DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    // Bit leaving the top digit means the value does not fit.
                    sticky <= sticky | acum_aj[ANCHO_BCD-1];
                    acum   <= desplazado[ANCHO_BCD+N_BITS-1 -: ANCHO_BCD];
                    desp   <= desplazado[N_BITS-1:0];
                    cnt    <= cnt - CNT_UNO;
                    if (cnt == CNT_UNO) begin
                        estado <= FIN;
                    end
                end
                FIN: begin
                    BCD      <= acum;
                    desborde <= sticky;
`ifdef BCD_APAGAR_CEROS_EN
                    apagar   <= apagar_d;
`endif
                    listo    <= 1'b1;
                    ocupado  <= 1'b0;
                    estado   <= IDLE;
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convertidor_bin_bcd_seq.sv
// Self-checking bench for convertidor_bin_bcd_seq (10-bit and 14-bit instances).
// Covers BCD_APAGAR_CEROS_EN when that macro is defined.
module tb_convertidor_bin_bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        desb;
        logic [3:0]  apag;
    } esperado_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inicio_a = 1'b0;
    logic        inicio_b = 1'b0;
    logic [9:0]  bin_a = '0;
    logic [13:0] bin_b = '0;
    logic        ocupado_a, listo_a, desb_a;
    logic        ocupado_b, listo_b, desb_b;
    logic [15:0] bcd_a, bcd_b;
`ifdef BCD_APAGAR_CEROS_EN
    logic [3:0]  apagar_a, apagar_b;
`endif

    int checks = 0;
    int failures = 0;
    int listo_cnt_a = 0;
    esperado_t cola_a[$];
    esperado_t cola_b[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (listo_a === 1'b1) listo_cnt_a++;

    convertidor_bin_bcd_seq #(.N_BITS(10), .N_DIGITOS(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .inicio    (inicio_a),
        .N_Binario (bin_a),
        .ocupado   (ocupado_a),
        .listo     (listo_a),
        .BCD       (bcd_a),
        .desborde  (desb_a)
`ifdef BCD_APAGAR_CEROS_EN
        ,
        .apagar    (apagar_a)
`endif
    );

    convertidor_bin_bcd_seq #(.N_BITS(14), .N_DIGITOS(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .inicio    (inicio_b),
        .N_Binario (bin_b),
        .ocupado   (ocupado_b),
        .listo     (listo_b),
        .BCD       (bcd_b),
        .desborde  (desb_b)
`ifdef BCD_APAGAR_CEROS_EN
        ,
        .apagar    (apagar_b)
`endif
    );

    function automatic esperado_t modelo(input int unsigned v);
        esperado_t   e;
        int unsigned p;
        logic        ceros;
        p      = 1;
        e.bcd  = '0;
        e.apag = '0;
        for (int i = 0; i < 4; i++) begin
            e.bcd[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        e.desb = (v >= p);
        ceros  = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            ceros     = ceros & (e.bcd[i*4 +: 4] == 4'd0);
            e.apag[i] = ceros;
        end
        return e;
    endfunction

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    task automatic arrancar(input bit big, input int unsigned v);
        @(negedge clk);
        if (big) begin
            bin_b    = 14'(v);
            inicio_b = 1'b1;
            cola_b.push_back(modelo(v));
        end else begin
            bin_a    = 10'(v);
            inicio_a = 1'b1;
            cola_a.push_back(modelo(v));
        end
        @(negedge clk);
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        // Input is already captured; scrambling it must not matter.
        bin_a = 10'($urandom);
        bin_b = 14'($urandom);
    endtask

    // Called on the negedge right after the accepting edge; lat_req < 0 skips timing checks.
    task automatic esperar_listo(input bit big, input int lat_req, input string tag);
        int        lat;
        int        occ;
        esperado_t e;
        lat = 0;
        occ = 0;
        while (!(big ? listo_b : listo_a) && lat < 60) begin
            if (big ? ocupado_b : ocupado_a) occ++;
            @(negedge clk);
            lat++;
        end
        comprobar({tag, "_listo_seen"}, 32'(big ? listo_b : listo_a), 32'd1);
        if (!(big ? listo_b : listo_a)) return;
        e = big ? cola_b.pop_front() : cola_a.pop_front();
        comprobar({tag, "_bcd"}, 32'(big ? bcd_b : bcd_a), 32'(e.bcd));
        comprobar({tag, "_desborde"}, 32'(big ? desb_b : desb_a), 32'(e.desb));
`ifdef BCD_APAGAR_CEROS_EN
        comprobar({tag, "_apagar"}, 32'(big ? apagar_b : apagar_a), 32'(e.apag));
`endif
        if (lat_req >= 0) begin
            comprobar({tag, "_latencia"}, 32'(lat), 32'(lat_req));
            comprobar({tag, "_ocupado_ciclos"}, 32'(occ), 32'(lat_req));
            comprobar({tag, "_ocupado_fin"}, 32'(big ? ocupado_b : ocupado_a), 32'd0);
        end
    endtask

    initial begin
        int lc;
        int unsigned secuencia[5];
        secuencia = '{0, 6, 17, 210, 1011};

        @(negedge clk);
        comprobar("rst_ocupado", 32'(ocupado_a), 32'd0);
        comprobar("rst_listo", 32'(listo_a), 32'd0);
        comprobar("rst_bcd", 32'(bcd_a), 32'd0);
        comprobar("rst_desborde", 32'(desb_a), 32'd0);
`ifdef BCD_APAGAR_CEROS_EN
        comprobar("rst_apagar", 32'(apagar_a), 32'd0);
`endif
        reset = 1'b0;

        arrancar(0, 1023);
        esperar_listo(0, 11, "max1023");

        foreach (secuencia[i]) begin
            arrancar(0, secuencia[i]);
            esperar_listo(0, 11, $sformatf("seq%0d", secuencia[i]));
            repeat (4) @(negedge clk);
            comprobar($sformatf("seq%0d_estable", secuencia[i]), 32'(bcd_a),
                      32'(modelo(secuencia[i]).bcd));
        end

        // Request during a conversion is dropped, not queued.
        #1 lc = listo_cnt_a;
        arrancar(0, 1023);
        repeat (3) @(negedge clk);
        bin_a    = 10'd5;
        inicio_a = 1'b1;
        @(negedge clk);
        inicio_a = 1'b0;
        esperar_listo(0, -1, "ignora");
        repeat (15) @(negedge clk);
        #1;
        comprobar("ignora_un_listo", 32'(listo_cnt_a - lc), 32'd1);
        comprobar("ignora_bcd", 32'(bcd_a), 32'h1023);

        // Reset in the middle of a conversion.
        arrancar(0, 1023);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        void'(cola_a.pop_back());
        lc = listo_cnt_a;
        comprobar("rstmid_ocupado", 32'(ocupado_a), 32'd0);
        comprobar("rstmid_listo", 32'(listo_a), 32'd0);
        comprobar("rstmid_bcd", 32'(bcd_a), 32'd0);
        comprobar("rstmid_desborde", 32'(desb_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        comprobar("rstmid_sin_listo", 32'(listo_cnt_a - lc), 32'd0);
        arrancar(0, 17);
        esperar_listo(0, 11, "post_rst17");

        // Wider input: overflow and latency N_BITS+1.
        arrancar(1, 12345);
        esperar_listo(1, 15, "w14_12345");
        arrancar(1, 9999);
        esperar_listo(1, 15, "w14_9999");

`ifdef BCD_APAGAR_CEROS_EN
        arrancar(0, 17);
        esperar_listo(0, 11, "apg17");
        comprobar("apg17_valor", 32'(apagar_a), 32'b1100);
        arrancar(0, 0);
        esperar_listo(0, 11, "apg0");
        comprobar("apg0_valor", 32'(apagar_a), 32'b1110);
        arrancar(0, 1023);
        esperar_listo(0, 11, "apg1023");
        comprobar("apg1023_valor", 32'(apagar_a), 32'b0000);
`endif

        comprobar("cola_a_vacia", 32'(cola_a.size()), 32'd0);
        comprobar("cola_b_vacia", 32'(cola_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/convertidor_bin_bcd_seq.md
Name: convertidor_bin_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble). It converts one unsigned N_BITS word per request into N_DIGITOS packed BCD digits over N_BITS shift cycles, with a start/done handshake and overflow detection. It is the multi-cycle, width-generic successor of the combinational 10-bit/4-digit converter, and feeds the display and monitoring path of the DPWM design.

Parameters:
N_BITS, 10, width of the unsigned binary input (>=1)
N_DIGITOS, 4, number of BCD output digits (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
inicio  input  1  conversion request; sampled only in IDLE
N_Binario  input  N_BITS  unsigned value; captured on the edge that accepts inicio
ocupado  output  1  high while a conversion is in progress
listo  output  1  one-cycle pulse when BCD/desborde are updated
BCD  output  4*N_DIGITOS  packed digits; [3:0]=units, [7:4]=tens, and so on upward
desborde  output  1  set when the value exceeds 10^N_DIGITOS-1; updated with BCD

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset values: ocupado=0, listo=0, BCD=0, desborde=0, state=IDLE, shift counter=0, internal registers=0.
- FSM states: IDLE, DESPLAZA, FIN.
- IDLE: if inicio=1 at edge k, capture N_Binario into the shift register, clear the BCD accumulator and the sticky overflow, load counter=N_BITS, then go to DESPLAZA. ocupado=1 from edge k.
- DESPLAZA: on each edge:
  - every accumulator digit >=5 gets +3;
  - then {accumulator, shift reg} shifts left by 1;
  - counter decrements;
  - the bit shifted out of the top digit ORs into the sticky overflow.
  - The state leaves for FIN on the edge where counter reaches 0, i.e. after exactly N_BITS shifts (edges k+1..k+N_BITS).
- FIN (one cycle): at edge k+N_BITS+1:
  - BCD <= accumulator, desborde <= sticky;
  - listo=1 for exactly the following cycle;
  - ocupado=0;
  - return to IDLE.
- Latency: result visible and listo high N_BITS+1 edges after the accepting edge. Minimum request spacing is N_BITS+2 cycles.
- inicio while ocupado=1 or during FIN: ignored, not queued. N_Binario changes after capture have no effect.
- BCD and desborde hold their last value between conversions. They change only at FIN or reset.
- Overflow: BCD = value mod 10^N_DIGITOS (truncated upper digits), desborde=1.
- Reset asserted mid-conversion: immediate return to reset values. The partial result is discarded and no listo is produced.
- Digit width fixed at 4. Add-3 compare is per digit, unsigned.

Optional Feature:
Macro BCD_APAGAR_CEROS_EN.
- Defined: adds output apagar [N_DIGITOS-1:0], registered at FIN alongside BCD. Bit i=1 when digit i and all higher digits are 0, for i>=1. Bit 0 is always 0, so a value of 0 shows a single "0". Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package convertidor_pkg:
  - FSM state encoding (IDLE/DESPLAZA/FIN);
  - constant ANCHO_DIGITO=4;
  - constant UMBRAL_AJUSTE=5;
  - constant AJUSTE=3;
  - counter width function clog2(N_BITS+1).
- Sub-module ajuste_digito: combinational 4-bit "if >=5 add 3" cell, instantiated N_DIGITOS times via generate.

Test Plan:
- Defaults; N_Binario=1023, inicio pulse -> ocupado 1 for 11 cycles, listo at edge+11, BCD=16'h1023, desborde=0.
- Sequence 0, 6, 17, 210, 1011 each waited to listo -> BCD 16'h0000, 16'h0006, 16'h0017, 16'h0210, 16'h1011; BCD stable between conversions.
- Start 1023, pulse inicio with N_Binario=5 at cycle 4 of the conversion -> ignored, result 16'h1023, exactly one listo.
- Start 1023, assert reset at cycle 5 -> all outputs 0 immediately, no listo, next request 17 yields 16'h0017.
- N_BITS=14, N_DIGITOS=4, N_Binario=12345 -> BCD=16'h2345, desborde=1, latency 15. Then 9999 -> 16'h9999, desborde=0.
- BCD_APAGAR_CEROS_EN defined: 17 -> apagar=4'b1100; 0 -> 4'b1110; 1023 -> 4'b0000.
